// File: rtl/div_ctrl_if.sv
// Issue, divider-core and writeback signals of div_ctrl, bundled into one interface.
// The slave modport is div_ctrl's view. The master modport is the surrounding pipeline and core.
interface div_ctrl_if #(
  parameter int unsigned WIDTH         = 64,
  parameter int unsigned TRANS_ID_BITS = 3
);
  logic                     flush_i;
  logic                     valid_i;
  logic                     ready_o;
  logic [2:0]               op_i;
  logic [WIDTH-1:0]         op_a_i;
  logic [WIDTH-1:0]         op_b_i;
  logic [TRANS_ID_BITS-1:0] trans_id_i;
  logic                     div_in_vld_o;
  logic                     div_in_rdy_i;
  logic [1:0]               div_opcode_o;
  logic [WIDTH-1:0]         div_op_a_o;
  logic [WIDTH-1:0]         div_op_b_o;
  logic [TRANS_ID_BITS-1:0] div_id_o;
  logic                     div_flush_o;
  logic                     div_out_vld_i;
  logic                     div_out_rdy_o;
  logic [WIDTH-1:0]         div_res_i;
  logic [TRANS_ID_BITS-1:0] div_id_i;
  logic                     result_valid_o;
  logic                     result_ready_i;
  logic [WIDTH-1:0]         result_o;
  logic [TRANS_ID_BITS-1:0] trans_id_o;

  modport slave (
    input  flush_i, valid_i, op_i, op_a_i, op_b_i, trans_id_i,
           div_in_rdy_i, div_out_vld_i, div_res_i, div_id_i, result_ready_i,
    output ready_o, div_in_vld_o, div_opcode_o, div_op_a_o, div_op_b_o, div_id_o,
           div_flush_o, div_out_rdy_o, result_valid_o, result_o, trans_id_o
  );

  modport master (
    output flush_i, valid_i, op_i, op_a_i, op_b_i, trans_id_i,
           div_in_rdy_i, div_out_vld_i, div_res_i, div_id_i, result_ready_i,
    input  ready_o, div_in_vld_o, div_opcode_o, div_op_a_o, div_op_b_o, div_id_o,
           div_flush_o, div_out_rdy_o, result_valid_o, result_o, trans_id_o
  );
endinterface

// File: rtl/div_ctrl.sv
// Issue/writeback wrapper around the serial divider core: prepares RV64M div/rem operands,
// drives the core handshake and buffers one post-processed result toward writeback.
module div_ctrl #(
  parameter int unsigned WIDTH         = 64,
  parameter int unsigned TRANS_ID_BITS = 3
) (
  input logic       clk_i,
  input logic       rst_ni,
  div_ctrl_if.slave bus
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_e;

  state_e                   r_state, w_state_d;
  logic [WIDTH-1:0]         r_op_a, r_op_b, r_res;
  logic                     r_word, r_res_vld;
  logic [1:0]               r_opcode;
  logic [TRANS_ID_BITS-1:0] r_id, r_res_id;
  logic [WIDTH-1:0]         w_op_a, w_op_b, w_res;
  logic                     w_issue, w_in_hs, w_out_hs;
  logic                     w_unused_id;

  // The core echoes the request ID, so div_id_i carries no new information here.
  assign w_unused_id = ^bus.div_id_i;

  assign w_issue  = bus.valid_i & bus.ready_o;
  assign w_in_hs  = bus.div_in_vld_o & bus.div_in_rdy_i;
  assign w_out_hs = bus.div_out_vld_i & bus.div_out_rdy_o;

  // W ops: signed variants (even op) sign-extend bit 31, unsigned variants zero-extend.
  always_comb begin
    w_op_a = bus.op_a_i;
    w_op_b = bus.op_b_i;
    if (bus.op_i[2]) begin
      if (!bus.op_i[0]) begin
        w_op_a = {{(WIDTH-32){bus.op_a_i[31]}}, bus.op_a_i[31:0]};
        w_op_b = {{(WIDTH-32){bus.op_b_i[31]}}, bus.op_b_i[31:0]};
      end else begin
        w_op_a = {{(WIDTH-32){1'b0}}, bus.op_a_i[31:0]};
        w_op_b = {{(WIDTH-32){1'b0}}, bus.op_b_i[31:0]};
      end
    end
  end

  assign w_res = r_word ? {{(WIDTH-32){bus.div_res_i[31]}}, bus.div_res_i[31:0]} : bus.div_res_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_d;
    end
  end

  always_comb begin
    w_state_d = r_state;
    unique case (r_state)
      IDLE:    if (w_issue)  w_state_d = REQ;
      REQ:     if (w_in_hs)  w_state_d = WAIT;
      WAIT:    if (w_out_hs) w_state_d = IDLE;
      default: w_state_d = IDLE;
    endcase
    if (bus.flush_i) w_state_d = IDLE;
  end

  always_comb begin
    bus.ready_o        = (r_state == IDLE) & ~bus.flush_i;
    bus.div_in_vld_o   = (r_state == REQ) & ~bus.flush_i;
    bus.div_out_rdy_o  = (r_state == WAIT) & ~bus.flush_i & (~r_res_vld | bus.result_ready_i);
    bus.div_opcode_o   = r_opcode;
    bus.div_op_a_o     = r_op_a;
    bus.div_op_b_o     = r_op_b;
    bus.div_id_o       = r_id;
    bus.div_flush_o    = bus.flush_i;
    bus.result_valid_o = r_res_vld;
    bus.result_o       = r_res;
    bus.trans_id_o     = r_res_id;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_op_a   <= '0;
      r_op_b   <= '0;
      r_word   <= 1'b0;
      r_opcode <= '0;
      r_id     <= '0;
    end else if (w_issue) begin
      r_op_a   <= w_op_a;
      r_op_b   <= w_op_b;
      r_word   <= bus.op_i[2];
      r_opcode <= {bus.op_i[1], ~bus.op_i[0]};
      r_id     <= bus.trans_id_i;
    end
  end

  // A load wins over a same-cycle consume, so the slot never drops a result.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_res_vld <= 1'b0;
      r_res     <= '0;
      r_res_id  <= '0;
    end else if (bus.flush_i) begin
      r_res_vld <= 1'b0;
    end else if (w_out_hs) begin
      r_res_vld <= 1'b1;
      r_res     <= w_res;
      r_res_id  <= r_id;
    end else if (bus.result_ready_i) begin
      r_res_vld <= 1'b0;
    end
  end

endmodule
